uart_tx_frame_gen: RTL and testbench
====================================

// Module: uart_tx_frame_gen
// PURPOSE
//  Parametrised UART transmitter, successor to the fixed 8N1 TX used by the Sphere link.
//  Configurable data width, parity mode and stop-bit count; baud divisor set at run time.
//  Ready/valid byte input; optional internal FIFO absorbs bursts from the command sequencer.
//  Drives the external serial TX pin; sits between the packet builder and the radio/BT module.
// PARAMETERS
//  DATA_BITS   8    payload bits per frame, legal 5..9, sent LSB first
//  PARITY      0    0 = none, 1 = odd, 2 = even
//  STOP_BITS   1    1 or 2
//  DIV_W       16   width of baud divisor input
//  FIFO_AW     3    FIFO address width, depth = 2**FIFO_AW (used only with UART_TX_FIFO_EN)
// PORTS
//  i_Clock          in   1          system clock
//  i_Rst_n          in   1          asynchronous reset, active low
//  i_Clks_Per_Bit   in   DIV_W      clocks per bit; values 0 and 1 are treated as 2
//  i_TX_DV          in   1          byte valid
//  i_TX_Byte        in   DATA_BITS  byte to send
//  o_TX_Ready       out  1          byte accepted on cycle where i_TX_DV && o_TX_Ready
//  o_TX_Active      out  1          frame in progress (start..last stop bit)
//  o_TX_Serial      out  1          serial line, idles high
//  o_TX_Done        out  1          one-cycle pulse at end of each frame
// BEHAVIOUR
//  - Reset (async, i_Rst_n=0): o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, FSM=IDLE,
//    counters=0, FIFO empty; o_TX_Ready=1 after reset release. Mid-frame reset aborts frame.
//  - FSM: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE.
//  - IDLE: line=1. On accept (direct) or FIFO non-empty, latch byte and divisor (clamped),
//    go START next cycle; o_TX_Active=1 from that cycle.
//  - Each bit held exactly D clocks (D = latched divisor); divisor changes mid-frame ignored.
//  - DATA: bit index 0..DATA_BITS-1, LSB first. PARITY: odd -> XNOR-reduce, even -> XOR-reduce
//    of the latched data. STOP: line=1 for STOP_BITS*D clocks.
//  - Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * D clocks, start-bit edge
//    to end of last stop bit.
//  - On last stop-bit clock: o_TX_Done pulses 1 cycle, o_TX_Active drops, FSM -> IDLE.
//    No cleanup state: a pending byte starts its start bit the cycle after IDLE is entered
//    (one idle-high clock between back-to-back frames).
//  - Latency: accept at cycle N -> o_TX_Serial falls at cycle N+1 (registered output).
//  - Counter: clock count is DIV_W bits, compares against D-1; no wrap within a bit.
//  - Illegal PARITY (>2) behaves as none; STOP_BITS other than 2 behaves as 1.
// CONFIGURATION
//  UART_TX_FIFO_EN defined: 2**FIFO_AW-entry FIFO on input; o_TX_Ready = !full; write on
//    i_TX_DV && o_TX_Ready; FSM pops in IDLE when non-empty; push and pop in the same cycle
//    both honoured (count unchanged); writes while full are dropped (ready=0 prevents them).
//  UART_TX_FIFO_EN undefined: no storage; o_TX_Ready = 1 only in IDLE (and not on the cycle
//    IDLE is left); i_TX_DV ignored when not ready.
// TESTING
//  1 8N1, D=4, send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 each 4 clks; Done pulse at clk 40.
//  2 PARITY=2, D=4, 0xA5 -> parity bit 0; PARITY=1 -> parity bit 1; frame 44 clks.
//  3 STOP_BITS=2, DATA_BITS=7, D=3, 0x55 -> stop high 6 clks; Active low after 30 clks.
//  4 i_Clks_Per_Bit=0 and =1 -> each bit 2 clks; change divisor 4->8 mid-frame -> stays 4.
//  5 FIFO_EN, FIFO_AW=3: push 9 bytes back-to-back -> Ready drops after 8/9 accepted,
//    all accepted bytes sent in order, 1 idle clk between frames; non-FIFO: Ready=0 in frame.
//  6 Assert i_Rst_n=0 mid DATA bit 3 -> Serial=1, Active=0 immediately; no Done pulse.

Source files
------------

// File: rtl/uart_tx_frame_gen.sv
// +----------------------------------------------------------------------------+
// | Module     : uart_tx_frame_gen                                             |
// | Description: Parametrised UART transmitter. Configurable data width,       |
// |              parity mode and stop-bit count; per-frame baud divisor        |
// |              latched at start. Optional input FIFO when the macro          |
// |              UART_TX_FIFO_EN is defined (direct ready/valid otherwise).    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_frame_gen #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16,
  parameter int FIFO_AW   = 3
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic [DIV_W-1:0]     i_Clks_Per_Bit,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_Byte,
  output logic                 o_TX_Ready,
  output logic                 o_TX_Active,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Done
);

  // Parity values other than 1/2 fall back to no parity; any stop count but 2 means 1.
  localparam bit                 c_HAS_PAR    = (PARITY == 1) || (PARITY == 2);
  localparam bit                 c_ODD_PAR    = (PARITY == 1);
  localparam bit                 c_TWO_STOP   = (STOP_BITS == 2);
  localparam int                 c_IDX_W      = $clog2(DATA_BITS);
  localparam logic [c_IDX_W-1:0] c_LAST_BIT   = c_IDX_W'(DATA_BITS - 1);
  localparam logic [DIV_W-1:0]   c_MIN_DIV_M1 = DIV_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DIV_W-1:0]      r_clk_cnt;
  logic [DIV_W-1:0]      w_cnt_nxt;
  logic [DIV_W-1:0]      r_div_m1;
  logic [DIV_W-1:0]      w_div_m1;
  logic [c_IDX_W-1:0]    r_bit_idx;
  logic [c_IDX_W-1:0]    w_bit_nxt;
  logic                  r_stop_idx;
  logic                  w_stop_nxt;
  logic [DATA_BITS-1:0]  r_shift;
  logic [DATA_BITS-1:0]  w_shift_nxt;
  logic                  r_parity;
  logic                  r_serial;
  logic                  w_serial_nxt;
  logic                  r_active;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  w_load;
  logic [DATA_BITS-1:0]  w_load_byte;
  logic                  w_load_par;
  logic                  w_bit_end;
  logic                  w_last_stop;

`ifdef UART_TX_FIFO_EN
  localparam int c_DEPTH = 2 ** FIFO_AW;

  logic [DATA_BITS-1:0] r_mem [c_DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr;
  logic [FIFO_AW-1:0]   r_rd_ptr;
  logic [FIFO_AW:0]     r_count;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;

  assign w_full      = (r_count == (FIFO_AW + 1)'(c_DEPTH));
  assign o_TX_Ready  = !w_full;
  assign w_push      = i_TX_DV && !w_full;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_load      = w_pop;
  assign w_load_byte = r_mem[r_rd_ptr];

  // FIFO storage: written on every accepted byte, no reset needed on the data.
  always_ff @(posedge i_Clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_TX_Byte;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  assign o_TX_Ready  = (r_state == S_IDLE);
  assign w_load      = i_TX_DV && (r_state == S_IDLE);
  assign w_load_byte = i_TX_Byte;
`endif

  // Divisors 0 and 1 are clamped to 2; the bit counter compares against D-1.
  assign w_div_m1    = (i_Clks_Per_Bit < DIV_W'(2)) ? c_MIN_DIV_M1 : i_Clks_Per_Bit - 1'b1;
  assign w_load_par  = c_ODD_PAR ? ~^w_load_byte : ^w_load_byte;
  assign w_bit_end   = (r_clk_cnt == r_div_m1);
  assign w_last_stop = !c_TWO_STOP || r_stop_idx;

  // Next-state, counters and the value the serial line will carry next cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_clk_cnt;
    w_bit_nxt    = r_bit_idx;
    w_stop_nxt   = r_stop_idx;
    w_shift_nxt  = r_shift;
    w_done_nxt   = 1'b0;
    w_serial_nxt = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_stop_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == c_LAST_BIT) begin
            w_state_nxt = c_HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            w_bit_nxt = r_bit_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (w_last_stop) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_stop_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    case (w_state_nxt)
      S_START:  w_serial_nxt = 1'b0;
      S_DATA:   w_serial_nxt = w_shift_nxt[0];
      S_PARITY: w_serial_nxt = r_parity;
      default:  w_serial_nxt = 1'b1;
    endcase
  end

  // State register plus registered line/status outputs; reset aborts any frame.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state    <= S_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_div_m1   <= '0;
      r_serial   <= 1'b1;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clk_cnt  <= w_cnt_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_stop_idx <= w_stop_nxt;
      r_serial   <= w_serial_nxt;
      r_active   <= (w_state_nxt != S_IDLE);
      r_done     <= w_done_nxt;
      if (w_load) begin
        r_shift  <= w_load_byte;
        r_parity <= w_load_par;
        r_div_m1 <= w_div_m1;
      end else begin
        r_shift  <= w_shift_nxt;
      end
    end
  end

  assign o_TX_Serial = r_serial;
  assign o_TX_Active = r_active;
  assign o_TX_Done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame_gen.sv
// +----------------------------------------------------------------------------+
// | Module     : tb_uart_tx_frame_gen                                          |
// | Description: Directed bench for uart_tx_frame_gen: 8N1, even/odd parity,   |
// |              7 data + 2 stop, divisor clamp/latch, back-to-back frames,    |
// |              FIFO burst (UART_TX_FIFO_EN) and mid-frame reset.             |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_frame_gen;

`ifdef UART_TX_FIFO_EN
  localparam bit c_FIFO = 1'b1;
`else
  localparam bit c_FIFO = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  dv;
  logic [7:0]  tbyte  [4];
  logic [15:0] div_in [4];
  logic [3:0]  ready;
  logic [3:0]  active;
  logic [3:0]  serial;
  logic [3:0]  done;

  int n_cmp;
  int n_err;

  // u0: 8N1, u1: 8E1, u2: 8O1, u3: 7N2
  uart_tx_frame_gen u0 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Clks_Per_Bit(div_in[0]), .i_TX_DV(dv[0]),
    .i_TX_Byte(tbyte[0]), .o_TX_Ready(ready[0]), .o_TX_Active(active[0]),
    .o_TX_Serial(serial[0]), .o_TX_Done(done[0]));

  uart_tx_frame_gen #(.PARITY(2)) u1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Clks_Per_Bit(div_in[1]), .i_TX_DV(dv[1]),
    .i_TX_Byte(tbyte[1]), .o_TX_Ready(ready[1]), .o_TX_Active(active[1]),
    .o_TX_Serial(serial[1]), .o_TX_Done(done[1]));

  uart_tx_frame_gen #(.PARITY(1)) u2 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Clks_Per_Bit(div_in[2]), .i_TX_DV(dv[2]),
    .i_TX_Byte(tbyte[2]), .o_TX_Ready(ready[2]), .o_TX_Active(active[2]),
    .o_TX_Serial(serial[2]), .o_TX_Done(done[2]));

  uart_tx_frame_gen #(.DATA_BITS(7), .STOP_BITS(2)) u3 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Clks_Per_Bit(div_in[3]), .i_TX_DV(dv[3]),
    .i_TX_Byte(tbyte[3][6:0]), .o_TX_Ready(ready[3]), .o_TX_Active(active[3]),
    .o_TX_Serial(serial[3]), .o_TX_Done(done[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte; returns #1 after the edge on which the start bit appears.
  task automatic send(input int k, input logic [7:0] b, input logic [15:0] div);
    @(negedge clk);
    dv[k]     = 1'b1;
    tbyte[k]  = b;
    div_in[k] = div;
    check_val($sformatf("u%0d ready before accept", k), 32'(ready[k]), 32'd1);
    @(posedge clk); #1;
    dv[k] = 1'b0;
    if (c_FIFO) begin
      @(posedge clk); #1;
    end
  endtask

  // Check every clock of a frame (bit i of frame is the i-th bit on the line),
  // ending #1 after the edge that finishes the last stop bit.
  task automatic check_frame(input int k, input logic [15:0] frame, input int nbits,
                             input int d, input string tag, input int chg_at,
                             input logic [15:0] new_div);
    for (int c = 0; c < nbits * d; c++) begin
      check_val($sformatf("%s serial c%0d", tag, c), 32'(serial[k]), 32'(frame[c / d]));
      check_val($sformatf("%s active c%0d", tag, c), 32'(active[k]), 32'd1);
      check_val($sformatf("%s done c%0d", tag, c), 32'(done[k]), 32'd0);
      check_val($sformatf("%s ready c%0d", tag, c), 32'(ready[k]), 32'(c_FIFO));
      if (c == chg_at) div_in[k] = new_div;
      @(posedge clk); #1;
    end
    check_val({tag, " done pulse"}, 32'(done[k]), 32'd1);
    check_val({tag, " active end"}, 32'(active[k]), 32'd0);
    check_val({tag, " serial end"}, 32'(serial[k]), 32'd1);
    check_val({tag, " ready end"}, 32'(ready[k]), 32'd1);
  endtask

  // One more clock after a lone frame: pulse gone, line idle.
  task automatic check_idle(input int k, input string tag);
    @(posedge clk); #1;
    check_val({tag, " done cleared"}, 32'(done[k]), 32'd0);
    check_val({tag, " serial idle"}, 32'(serial[k]), 32'd1);
  endtask

  logic [15:0] fr;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    dv    = '0;
    for (int k = 0; k < 4; k++) begin
      tbyte[k]  = 8'h00;
      div_in[k] = 16'd4;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("u%0d reset serial", k), 32'(serial[k]), 32'd1);
      check_val($sformatf("u%0d reset active", k), 32'(active[k]), 32'd0);
      check_val($sformatf("u%0d reset done", k), 32'(done[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("ready after reset", 32'(ready[0]), 32'd1);

    // 8N1, D=4, 0xA5: 0 | 1,0,1,0,0,1,0,1 | 1
    fr = 16'b000000_1_10100101_0;
    send(0, 8'hA5, 16'd4);
    check_frame(0, fr, 10, 4, "8N1", -1, 16'd0);
    check_idle(0, "8N1");

    // Even parity on 0xA5 (four ones) -> 0
    fr = 16'b00000_1_0_10100101_0;
    send(1, 8'hA5, 16'd4);
    check_frame(1, fr, 11, 4, "8E1", -1, 16'd0);
    check_idle(1, "8E1");

    // Odd parity on 0xA5 -> 1
    fr = 16'b00000_1_1_10100101_0;
    send(2, 8'hA5, 16'd4);
    check_frame(2, fr, 11, 4, "8O1", -1, 16'd0);
    check_idle(2, "8O1");

    // 7 data bits 0x55, two stop bits, D=3 -> 30 clocks
    fr = 16'b000000_11_1010101_0;
    send(3, 8'h55, 16'd3);
    check_frame(3, fr, 10, 3, "7N2", -1, 16'd0);
    check_idle(3, "7N2");

    // Divisor clamp: 0 and 1 both give 2 clocks per bit
    fr = 16'b000000_1_10100101_0;
    send(0, 8'hA5, 16'd0);
    check_frame(0, fr, 10, 2, "div0", -1, 16'd0);
    check_idle(0, "div0");
    send(0, 8'hA5, 16'd1);
    check_frame(0, fr, 10, 2, "div1", -1, 16'd0);
    check_idle(0, "div1");

    // Divisor 4 -> 8 mid-frame: frame keeps 4 clocks per bit
    send(0, 8'hA5, 16'd4);
    check_frame(0, fr, 10, 4, "divchg", 10, 16'd8);
    check_idle(0, "divchg");

    // Back-to-back 0x11 then 0x22, D=2: one idle-high clock between frames
    @(negedge clk);
    dv[0]     = 1'b1;
    tbyte[0]  = 8'h11;
    div_in[0] = 16'd2;
    @(posedge clk); #1;
    tbyte[0] = 8'h22;
    if (c_FIFO) begin
      @(posedge clk); #1;
      dv[0] = 1'b0;
    end
    fr = 16'b000000_1_00010001_0;
    check_frame(0, fr, 10, 2, "b2b first", -1, 16'd0);
    @(posedge clk); #1;
    dv[0] = 1'b0;
    fr = 16'b000000_1_00100010_0;
    check_frame(0, fr, 10, 2, "b2b second", -1, 16'd0);
    check_idle(0, "b2b");

`ifdef UART_TX_FIFO_EN
    // Burst of 10 bytes into an 8-deep FIFO: 9 accepted, sent in order
    begin
      int acc;
      acc = 0;
      div_in[0] = 16'd2;
      fork
        begin
          for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dv[0]    = 1'b1;
            tbyte[0] = 8'(i + 1);
            if (ready[0]) acc++;
            @(posedge clk);
          end
          #1;
          dv[0] = 1'b0;
        end
        begin
          for (int j = 0; j < 9; j++) begin
            logic [7:0] rx;
            int t;
            t  = 0;
            rx = '0;
            while (serial[0] !== 1'b0 && t < 200) begin
              @(posedge clk); #1;
              t++;
            end
            check_val($sformatf("fifo start %0d timeout", j), 32'(t < 200), 32'd1);
            for (int b = 0; b < 8; b++) begin
              repeat (2) @(posedge clk);
              #1;
              rx[b] = serial[0];
            end
            repeat (2) @(posedge clk);
            #1;
            check_val($sformatf("fifo byte %0d", j), 32'(rx), 32'(j + 1));
          end
        end
      join
      check_val("fifo accepted count", 32'(acc), 32'd9);
      repeat (30) @(posedge clk);
    end
`endif

    // Reset during data bit 3 of 0xA5 (line low there): line idles at once, no Done
    send(0, 8'hA5, 16'd4);
    repeat (17) @(posedge clk);
    #1;
    check_val("pre-reset serial bit3", 32'(serial[0]), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid-frame reset serial", 32'(serial[0]), 32'd1);
    check_val("mid-frame reset active", 32'(active[0]), 32'd0);
    check_val("mid-frame reset done", 32'(done[0]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_val($sformatf("post-reset done %0d", i), 32'(done[0]), 32'd0);
      check_val($sformatf("post-reset active %0d", i), 32'(active[0]), 32'd0);
      check_val($sformatf("post-reset serial %0d", i), 32'(serial[0]), 32'd1);
    end
    check_val("post-reset ready", 32'(ready[0]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
